regfile_rd2w1: RTL
==================

// Module: regfile_rd2w1
// PURPOSE
//  Parametrised register file with registered selection, replacing the combinational 4:1 byte mux.
//  Provides one write port, two read ports, a sequenced clear-all, and out-of-range error flagging.
//  Sits between the BPF decode stage (register indices) and the ALU operand inputs.
//  Read data is registered, so operands arrive one cycle after the request.
// PARAMETERS
//  DATA_W  8  width of each register entry, bits
//  DEPTH   4  number of entries, >=1; need not be a power of two
//  ADDR_W  (DEPTH>1 ? $clog2(DEPTH) : 1)  index width; derived, do not override
// PORTS
//  iCLK        in   1       clock; all state changes on the rising edge
//  inRESET     in   1       asynchronous reset, active-low
//  iWR_EN      in   1       write strobe
//  iWR_ADDR    in   ADDR_W  write index
//  iWR_DATA    in   DATA_W  write data
//  iRD_REQ     in   1       read request; samples both read indices
//  iRD_ADDR_A  in   ADDR_W  read index, port A
//  iRD_ADDR_B  in   ADDR_W  read index, port B
//  iCLEAR      in   1       start the clear-all sequence
//  oRD_DATA_A  out  DATA_W  registered read data, port A
//  oRD_DATA_B  out  DATA_W  registered read data, port B
//  oRD_VALID   out  1       one-cycle pulse; oRD_DATA_A/B are valid
//  oRD_ERR     out  1       qualifies oRD_VALID; an index was >= DEPTH
//  oBUSY       out  1       high while the clear sequence runs
// BEHAVIOUR
//  Reset (inRESET=0, asynchronous):
//   - all entries := 0; FSM := IDLE; clear counter := 0.
//   - oRD_DATA_A/B, oRD_VALID, oRD_ERR, oBUSY := 0.
//  FSM: IDLE, CLEAR.
//   - IDLE->CLEAR on an edge with iCLEAR=1.
//   - CLEAR->IDLE on the edge that zeroes entry DEPTH-1.
//  CLEAR sequence:
//   - Zeroes entry cnt at each edge, cnt = 0..DEPTH-1; takes exactly DEPTH cycles.
//   - oBUSY = (state==CLEAR), registered; it is high for DEPTH cycles starting the cycle after iCLEAR.
//   - iCLEAR while in CLEAR is ignored; the sequence does not restart.
//  Write (IDLE only):
//   - At the edge with iWR_EN=1 and iWR_ADDR<DEPTH, entry[iWR_ADDR] := iWR_DATA.
//   - iWR_ADDR>=DEPTH: write is dropped silently; no flag.
//  Read (IDLE only), latency 1:
//   - Request sampled at edge k; at edge k, oRD_VALID:=1 and oRD_DATA_A/B := selected entries.
//   - oRD_VALID is a single-cycle pulse per request; back-to-back requests give back-to-back pulses.
//   - Without a request, oRD_VALID:=0 and oRD_DATA_A/B hold their previous values.
//  Write/read bypass:
//   - Same-edge write and read of the same in-range index return iWR_DATA.
//   - This is write-first, applied independently per read port.
//  Out-of-range read (iRD_ADDR_x >= DEPTH): that port's data := 0, oRD_ERR := 1 with oRD_VALID.
//  oRD_ERR is 0 whenever oRD_VALID=0.
//  Simultaneous events in IDLE:
//   - iCLEAR + iWR_EN: clear wins; the write is dropped.
//   - iCLEAR + iRD_REQ: the read is serviced with pre-clear contents; oRD_VALID pulses the next cycle.
//  In CLEAR:
//   - iWR_EN and iRD_REQ are ignored; oRD_VALID stays 0.
//   - The requester must gate its strobes on oBUSY.
//  Reset asserted mid-CLEAR: everything returns to reset values immediately; the sequence is abandoned.
//  DEPTH=1: the index is 1 bit; index 1 is out of range.
// TESTING
//  1. Reset, then read A=0,B=3 -> next cycle VALID=1, A=0x00, B=0x00, ERR=0.
//  2. Write 0xA5->1, 0x3C->2, then read A=1,B=2 -> VALID=1, A=0xA5, B=0x3C; VALID low the following cycle.
//  3. Write 0x77->3 on the same edge as read A=3,B=3 -> A=B=0x77 (bypass).
//  4. Fill entries with 0x11..0x44, pulse iCLEAR with iWR_EN(0xFF->0) -> BUSY high 4 cycles, then all reads 0; write lost.
//  5. Read during BUSY -> no VALID; assert inRESET on 2nd clear cycle -> BUSY=0 at once, FSM IDLE.
//  6. DEPTH=5, DATA_W=16: read A=4,B=6 -> VALID=1, ERR=1, B=0x0000, A=entry4; write to 7 -> no entry changes.

Source files
------------

// File: rtl/regfile_rd2w1.sv
// regfile_rd2w1 -- parametrised register file: one write port, two registered
// read ports, a sequenced clear-all and out-of-range read flagging.
// Feeds ALU operands from decoded register indices; read data arrives one
// cycle after the request.
//
// Ports:
//   iCLK        clock, rising edge
//   inRESET     asynchronous reset, active-low
//   iWR_EN      write strobe (IDLE only)
//   iWR_ADDR    write index; indices >= DEPTH are dropped silently
//   iWR_DATA    write data
//   iRD_REQ     read request; samples both read indices (IDLE only)
//   iRD_ADDR_A  read index, port A
//   iRD_ADDR_B  read index, port B
//   iCLEAR      start clear-all (zeroes one entry per cycle)
//   oRD_DATA_A  registered read data, port A (holds between requests)
//   oRD_DATA_B  registered read data, port B (holds between requests)
//   oRD_VALID   one-cycle pulse per serviced request
//   oRD_ERR     with oRD_VALID: a read index was >= DEPTH
//   oBUSY       high while the clear sequence runs
module regfile_rd2w1 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              iCLK,
  input  logic              inRESET,
  input  logic              iWR_EN,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [DATA_W-1:0] iWR_DATA,
  input  logic              iRD_REQ,
  input  logic [ADDR_W-1:0] iRD_ADDR_A,
  input  logic [ADDR_W-1:0] iRD_ADDR_B,
  input  logic              iCLEAR,
  output logic [DATA_W-1:0] oRD_DATA_A,
  output logic [DATA_W-1:0] oRD_DATA_B,
  output logic              oRD_VALID,
  output logic              oRD_ERR,
  output logic              oBUSY
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] regMem [DEPTH];

  logic [0:0]        state;
  logic [0:0]        nextState;
  logic [ADDR_W-1:0] clrCnt;
  logic [ADDR_W-1:0] nextClrCnt;

  logic              wrGo;
  logic              rdGo;
  logic              wrInRange;
  logic              rdInRangeA;
  logic              rdInRangeB;
  logic [DATA_W-1:0] selA;
  logic [DATA_W-1:0] selB;

  logic [DATA_W-1:0] nextDataA;
  logic [DATA_W-1:0] nextDataB;
  logic              nextValid;
  logic              nextErr;
  logic              nextBusy;

  // Index range checks; zero-extension keeps non-power-of-two depths exact.
  always_comb begin
    wrInRange  = (32'(iWR_ADDR)   < DEPTH);
    rdInRangeA = (32'(iRD_ADDR_A) < DEPTH);
    rdInRangeB = (32'(iRD_ADDR_B) < DEPTH);
  end

  // Entry select per read port, compare-based so no array index exceeds DEPTH.
  always_comb begin
    selA = '0;
    selB = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (iRD_ADDR_A == ADDR_W'(i)) selA = regMem[i];
      if (iRD_ADDR_B == ADDR_W'(i)) selB = regMem[i];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    nextState  = state;
    nextClrCnt = '0;
    wrGo       = 1'b0;
    rdGo       = 1'b0;
    nextDataA  = oRD_DATA_A;
    nextDataB  = oRD_DATA_B;
    nextValid  = 1'b0;
    nextErr    = 1'b0;

    case (state)
      IDLE: begin
        // Clear takes priority over a same-edge write; a same-edge read is
        // still serviced from the pre-clear contents.
        wrGo = iWR_EN && wrInRange && !iCLEAR;
        rdGo = iRD_REQ;
        if (iCLEAR) nextState = CLEAR;
      end
      CLEAR: begin
        if (clrCnt == LAST_IDX) begin
          nextState = IDLE;
        end else begin
          nextClrCnt = clrCnt + ADDR_W'(1);
        end
      end
      default: nextState = IDLE;
    endcase

    if (rdGo) begin
      nextValid = 1'b1;
      nextErr   = !rdInRangeA || !rdInRangeB;
      // Write-first bypass, resolved independently for each port.
      if (!rdInRangeA)                          nextDataA = '0;
      else if (wrGo && iWR_ADDR == iRD_ADDR_A)  nextDataA = iWR_DATA;
      else                                      nextDataA = selA;
      if (!rdInRangeB)                          nextDataB = '0;
      else if (wrGo && iWR_ADDR == iRD_ADDR_B)  nextDataB = iWR_DATA;
      else                                      nextDataB = selB;
    end

    nextBusy = (nextState == CLEAR);
  end

  // State, counter and output registers.
  always_ff @(posedge iCLK or negedge inRESET) begin
    if (!inRESET) begin
      state      <= IDLE;
      clrCnt     <= '0;
      oRD_DATA_A <= '0;
      oRD_DATA_B <= '0;
      oRD_VALID  <= 1'b0;
      oRD_ERR    <= 1'b0;
      oBUSY      <= 1'b0;
    end else begin
      state      <= nextState;
      clrCnt     <= nextClrCnt;
      oRD_DATA_A <= nextDataA;
      oRD_DATA_B <= nextDataB;
      oRD_VALID  <= nextValid;
      oRD_ERR    <= nextErr;
      oBUSY      <= nextBusy;
    end
  end

  // Storage: clear sweep zeroes entry clrCnt; otherwise accept the write.
  always_ff @(posedge iCLK or negedge inRESET) begin
    if (!inRESET) begin
      for (int i = 0; i < int'(DEPTH); i++) regMem[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (state == CLEAR && clrCnt == ADDR_W'(i)) begin
          regMem[i] <= '0;
        end else if (wrGo && iWR_ADDR == ADDR_W'(i)) begin
          regMem[i] <= iWR_DATA;
        end
      end
    end
  end

endmodule
